heap_cmd_queue: RTL and testbench

HEAP_CMD_QUEUE -- requirements
Module: heap_cmd_queue

---
 rtl/heap_pkg.sv | 48 ++++
 rtl/heap_cmd_fifo.sv | 64 ++++++
 rtl/heap_cmd_queue.sv | 120 ++++++++++++
 tb/tb_heap_cmd_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap unit and its command queue: opcodes,
// discard codes, sequencing-FSM encoding and the queued command record.
package heap_pkg;

  localparam logic [4:0] OP_PUSH = 5'd0;
  localparam logic [4:0] OP_POP  = 5'd1;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FULL    = 2'd1,
    ERR_EMPTY   = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WAIT   = 2'd3
  } heap_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } heap_cmd_t;

  localparam int CMD_W = $bits(heap_cmd_t);

  // Decides whether a head command may go to the heap given the predicted
  // occupancy; any non-NONE result means the command is dropped.
  function automatic err_code_e head_check(
    input logic [4:0] rd,
    input logic       occ_at_max,
    input logic       occ_at_zero
  );
    err_code_e code;
    code = ERR_NONE;
    if (rd == OP_PUSH) begin
      if (occ_at_max) code = ERR_FULL;
    end else if (rd == OP_POP) begin
      if (occ_at_zero) code = ERR_EMPTY;
    end else begin
      code = ERR_ILLEGAL;
    end
    return code;
  endfunction

endpackage

// File: rtl/heap_cmd_fifo.sv
// Circular command buffer in front of the heap sequencer; flush wins over
// a same-cycle enqueue, and the count comes straight from a register.
module heap_cmd_fifo
  import heap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_enq,
  input  logic [CMD_W-1:0] i_enq_cmd,
  input  logic             i_deq,
  output logic [CMD_W-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_enq;
  logic w_do_deq;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rd_ptr];
  assign w_do_enq = i_enq && !o_full && !i_flush;
  assign w_do_deq = i_deq && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count guarantees no stale entry is ever
  // consumed, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_enq_cmd;
  end

endmodule

// File: rtl/heap_cmd_queue.sv
// Command queue for the heap unit: buffers core commands, issues them one
// at a time paced by heap_busy, and drops commands the heap would reject.
module heap_cmd_queue
  import heap_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int HEAP_SIZE = 25
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_v,
  output logic                           in_ready,
  input  logic [4:0]                     in_rd,
  input  logic [31:0]                    in_data,
  input  logic                           flush,
  input  logic                           heap_busy,
  output logic                           iss_v,
  output logic [4:0]                     iss_rd,
  output logic [31:0]                    iss_data,
  output logic                           err_v,
  output logic [1:0]                     err_code,
  output logic [$clog2(HEAP_SIZE+1)-1:0] occ
);

  localparam int OCC_W = $clog2(HEAP_SIZE + 1);

  heap_state_e      r_state;
  heap_state_e      w_next_state;
  logic [OCC_W-1:0] r_occ;
  logic [4:0]       r_iss_rd;
  logic [31:0]      r_iss_data;
  logic             r_err_v;
  err_code_e        r_err_code;

  logic [CMD_W-1:0] w_head_bits;
  heap_cmd_t        w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_enq;
  logic             w_deq;
  logic             w_issue;
  logic             w_discard;
  err_code_e        w_head_err;

  assign in_ready = !w_full;
  assign w_enq    = in_v && in_ready;
  assign w_head   = w_head_bits;

  heap_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_flush   (flush),
    .i_enq     (w_enq),
    .i_enq_cmd ({in_rd, in_data}),
    .i_deq     (w_deq),
    .o_head    (w_head_bits),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  // The occupancy is a prediction: it moves when a command is handed over,
  // so back-to-back checks against it stay consistent with issue order.
  assign w_head_err = head_check(w_head.rd,
                                 r_occ == OCC_W'(HEAP_SIZE),
                                 r_occ == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue)    w_next_state = ST_ISSUE;
      ST_ISSUE:                  w_next_state = ST_SETTLE;
      ST_SETTLE:                 w_next_state = ST_WAIT;
      ST_WAIT:   if (!heap_busy) w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    iss_v     = (r_state == ST_ISSUE);
    w_deq     = (r_state == ST_IDLE) && !w_empty;
    w_issue   = w_deq && (w_head_err == ERR_NONE);
    w_discard = w_deq && (w_head_err != ERR_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ      <= '0;
      r_iss_rd   <= '0;
      r_iss_data <= '0;
      r_err_v    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err_v <= w_discard;
      if (w_discard) r_err_code <= w_head_err;
      if (w_issue) begin
        r_iss_rd   <= w_head.rd;
        r_iss_data <= w_head.data;
        // head_check has already excluded overflow and underflow here
        if (w_head.rd == OP_PUSH) r_occ <= r_occ + OCC_W'(1);
        else                      r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

  assign iss_rd   = r_iss_rd;
  assign iss_data = r_iss_data;
  assign err_v    = r_err_v;
  assign err_code = r_err_code;
  assign occ      = r_occ;

endmodule

// File: tb/tb_heap_cmd_queue.sv
// Directed bench for heap_cmd_queue: a table of single commands plus
// hand-written sequences for back-pressure, heap fill, flush and reset.
module tb_heap_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        flush;
  logic        heap_busy;
  logic        iss_v;
  logic [4:0]  iss_rd;
  logic [31:0] iss_data;
  logic        err_v;
  logic [1:0]  err_code;
  logic [4:0]  occ;

  int n_checks = 0;
  int n_errors = 0;

  // heap unit model: busy for busy_len negedges after seeing an issue
  int busy_len = 0;
  int busy_cnt = 0;
  int cyc = 0;
  int dbl_iss = 0;
  logic prev_iss = 1'b0;
  logic [36:0] iss_q[$];
  int          iss_cyc_q[$];
  logic [1:0]  err_q[$];

  heap_cmd_queue #(.DEPTH(4), .HEAP_SIZE(25)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_v      (in_v),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .flush     (flush),
    .heap_busy (heap_busy),
    .iss_v     (iss_v),
    .iss_rd    (iss_rd),
    .iss_data  (iss_data),
    .err_v     (err_v),
    .err_code  (err_code),
    .occ       (occ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign heap_busy = reset && (busy_cnt != 0);

  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
      prev_iss = 1'b0;
    end else begin
      if (iss_v) begin
        iss_q.push_back({iss_rd, iss_data});
        iss_cyc_q.push_back(cyc);
        if (prev_iss) dbl_iss++;
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      prev_iss = iss_v;
      if (err_v) err_q.push_back(err_code);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_q();
    #1;
    iss_q.delete();
    iss_cyc_q.delete();
    err_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_v = 1'b0; in_rd = '0; in_data = '0; flush = 1'b0;
    busy_len = 0;
    repeat (2) @(negedge clk);
    iss_q.delete(); iss_cyc_q.delete(); err_q.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called just after a negedge; returns at the negedge after acceptance.
  task automatic enq(input logic [4:0] rd, input logic [31:0] d);
    int t = 0;
    in_v = 1'b1; in_rd = rd; in_data = d;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("enq_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_v = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_iss;
    logic [1:0]  exp_err;
    logic [4:0]  exp_occ;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    vecs[0] = '{5'd1,  32'h0,        1'b0, 2'd2, 5'd0};
    vecs[1] = '{5'd0,  32'd5,        1'b1, 2'd0, 5'd1};
    vecs[2] = '{5'd0,  32'hDEADBEEF, 1'b1, 2'd0, 5'd2};
    vecs[3] = '{5'd7,  32'h11,       1'b0, 2'd3, 5'd2};
    vecs[4] = '{5'd1,  32'h0,        1'b1, 2'd0, 5'd1};
    vecs[5] = '{5'd31, 32'h22,       1'b0, 2'd3, 5'd1};
    vecs[6] = '{5'd1,  32'h0,        1'b1, 2'd0, 5'd0};
    vecs[7] = '{5'd1,  32'h0,        1'b0, 2'd2, 5'd0};
    vecs[8] = '{5'd2,  32'h33,       1'b0, 2'd3, 5'd0};
    vecs[9] = '{5'd0,  32'hFFFFFFFF, 1'b1, 2'd0, 5'd1};

    // reset values, observed with no clock edge after assertion
    reset = 1'b0;
    in_v = 1'b0; in_rd = '0; in_data = '0; flush = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_iss_v",    {63'd0, iss_v},    64'd0);
    check("rst_err_v",    {63'd0, err_v},    64'd0);
    check("rst_occ",      {59'd0, occ},      64'd0);
    do_reset();

    // first-issue latency: accepted at E0, iss_v high between E1 and E2
    in_v = 1'b1; in_rd = 5'd0; in_data = 32'd5;
    @(negedge clk);
    in_v = 1'b0;
    check("lat_e0_iss_v", {63'd0, iss_v}, 64'd0);
    @(negedge clk);
    check("lat_e1_iss_v",    {63'd0, iss_v},  64'd1);
    check("lat_e1_iss_rd",   {59'd0, iss_rd}, 64'd0);
    check("lat_e1_iss_data", {32'd0, iss_data}, 64'd5);
    check("lat_e1_occ",      {59'd0, occ},    64'd1);
    @(negedge clk);
    check("lat_e2_iss_v",    {63'd0, iss_v},  64'd0);
    check("lat_hold_data",   {32'd0, iss_data}, 64'd5);

    // table of single commands applied in sequence from an empty heap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      clr_q();
      enq(vecs[i].rd, vecs[i].data);
      repeat (8) @(negedge clk);
      if (vecs[i].exp_iss) begin
        check($sformatf("vec%0d_iss_cnt", i), iss_q.size(), 1);
        check($sformatf("vec%0d_err_cnt", i), err_q.size(), 0);
        if (iss_q.size() > 0)
          check($sformatf("vec%0d_iss_val", i), {27'd0, iss_q[0]}, {27'd0, vecs[i].rd, vecs[i].data});
      end else begin
        check($sformatf("vec%0d_iss_cnt", i), iss_q.size(), 0);
        check($sformatf("vec%0d_err_cnt", i), err_q.size(), 1);
        if (err_q.size() > 0)
          check($sformatf("vec%0d_err_code", i), {62'd0, err_q[0]}, {62'd0, vecs[i].exp_err});
      end
      check($sformatf("vec%0d_occ", i), {59'd0, occ}, {59'd0, vecs[i].exp_occ});
    end
    check("err_code_hold", {62'd0, err_code}, 64'd3);

    // back-pressure: five back-to-back pushes with a slow heap
    do_reset();
    busy_len = 6;
    for (int i = 0; i < 5; i++) enq(5'd0, 32'd10 + 32'(i));
    check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    repeat (50) @(negedge clk);
    check("bp_iss_cnt", iss_q.size(), 5);
    bad = 0;
    for (int i = 0; i < iss_q.size(); i++)
      if (iss_q[i] !== {5'd0, 32'd10 + 32'(i)}) bad++;
    check("bp_order", bad, 0);
    bad = 0;
    for (int i = 1; i < iss_cyc_q.size(); i++)
      if (iss_cyc_q[i] - iss_cyc_q[i-1] != 8) bad++;
    check("bp_gap", bad, 0);
    check("bp_occ", {59'd0, occ}, 64'd5);
    check("bp_in_ready_drained", {63'd0, in_ready}, 64'd1);

    // heap fill: 25 pushes, 26th rejected, illegal opcode, pop at the top
    do_reset();
    for (int i = 0; i < 26; i++) enq(5'd0, 32'd100 + 32'(i));
    repeat (20) @(negedge clk);
    check("fill_iss_cnt", iss_q.size(), 25);
    bad = 0;
    for (int i = 0; i < iss_q.size(); i++)
      if (iss_q[i] !== {5'd0, 32'd100 + 32'(i)}) bad++;
    check("fill_order", bad, 0);
    check("fill_err_cnt", err_q.size(), 1);
    if (err_q.size() > 0) check("fill_err_code", {62'd0, err_q[0]}, 64'd1);
    check("fill_occ", {59'd0, occ}, 64'd25);
    clr_q();
    enq(5'd7, 32'd0);
    repeat (8) @(negedge clk);
    check("ill_err_cnt", err_q.size(), 1);
    if (err_q.size() > 0) check("ill_err_code", {62'd0, err_q[0]}, 64'd3);
    check("ill_occ", {59'd0, occ}, 64'd25);
    clr_q();
    enq(5'd1, 32'd0);
    repeat (8) @(negedge clk);
    check("top_pop_iss_cnt", iss_q.size(), 1);
    check("top_pop_occ", {59'd0, occ}, 64'd24);

    // flush during WAIT, with a same-cycle enqueue that must be dropped
    do_reset();
    busy_len = 6;
    enq(5'd0, 32'hA);
    enq(5'd0, 32'hB);
    enq(5'd0, 32'hC);
    @(negedge clk);
    check("flush_pre_iss_cnt", iss_q.size(), 1);
    flush = 1'b1; in_v = 1'b1; in_rd = 5'd0; in_data = 32'hD;
    @(negedge clk);
    flush = 1'b0; in_v = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (30) @(negedge clk);
    check("flush_iss_cnt", iss_q.size(), 1);
    if (iss_q.size() > 0) check("flush_iss_val", {27'd0, iss_q[0]}, {27'd0, 5'd0, 32'hA});
    check("flush_err_cnt", err_q.size(), 0);
    check("flush_occ", {59'd0, occ}, 64'd1);

    // reset asserted mid-WAIT with two commands still queued
    do_reset();
    busy_len = 6;
    enq(5'd7, 32'h0);
    enq(5'd0, 32'hA1);
    enq(5'd0, 32'hB2);
    enq(5'd0, 32'hC3);
    @(negedge clk);
    check("rw_pre_err_code", {62'd0, err_code}, 64'd3);
    check("rw_pre_iss_data", {32'd0, iss_data}, 64'hA1);
    reset = 1'b0;
    #1;
    check("rw_iss_v",    {63'd0, iss_v},    64'd0);
    check("rw_err_v",    {63'd0, err_v},    64'd0);
    check("rw_err_code", {62'd0, err_code}, 64'd0);
    check("rw_iss_rd",   {59'd0, iss_rd},   64'd0);
    check("rw_iss_data", {32'd0, iss_data}, 64'd0);
    check("rw_occ",      {59'd0, occ},      64'd0);
    check("rw_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    iss_q.delete(); iss_cyc_q.delete(); err_q.delete();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("rw_post_iss_cnt", iss_q.size(), 0);
    check("rw_post_err_cnt", err_q.size(), 0);
    check("rw_post_occ", {59'd0, occ}, 64'd0);

    check("iss_single_cycle", dbl_iss, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
